// File: rtl/pe_mac_acc_unit.sv
// pe_mac_acc_unit
// Signed multiply-accumulate cell for the conv PE array. Multiplies a feature
// sample by a latched (or bypassed) kernel weight. Chain mode adds the incoming
// partial sum for systolic shift-accumulate. Local mode accumulates TAPS
// products into one result per group. All adds saturate to ACC_W bits.
module pe_mac_acc_unit #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 20,
    parameter int TAPS     = 9,
    parameter int MUL_LAT  = 1
) (
    input  logic                       s_clk,
    input  logic                       s_rst,
    input  logic                       k_weight_valid,
    input  logic signed [WEIGHT_W-1:0] kernel_weight,
    input  logic                       f_data_valid,
    input  logic signed [DATA_W-1:0]   feature_data,
    input  logic signed [ACC_W-1:0]    shift_data,
    input  logic                       i_mode,
    input  logic                       i_clear,
    output logic                       o_mac_rlst_valid,
    output logic signed [ACC_W-1:0]    o_mac_rlst_out,
    output logic                       o_sat
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int CNT_W  = $clog2(TAPS + 1);
    localparam int LAST   = MUL_LAT - 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    if (ACC_W < PROD_W || TAPS < 2 || MUL_LAT < 1) begin : g_param_check
        $error("pe_mac_acc_unit: ACC_W must cover the product, TAPS >= 2, MUL_LAT >= 1");
    end

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } state_t;

    // One guard bit above ACC_W so overflow of a two-operand add is always visible.
    function automatic logic signed [ACC_W:0] wide_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] a_w;
        logic signed [ACC_W:0] b_w;
        a_w = {a[ACC_W-1], a};
        b_w = {b[ACC_W-1], b};
        return a_w + b_w;
    endfunction

    // Guard bit disagreeing with the ACC_W sign bit means the sum left the range.
    function automatic logic sat_ovf(input logic signed [ACC_W:0] s);
        return s[ACC_W] != s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] s);
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_W-1:0];
    endfunction

    logic signed [WEIGHT_W-1:0] wt_q;
    logic signed [WEIGHT_W-1:0] eff_wt;

    logic                       vld_p0   [MUL_LAT];
    logic signed [DATA_W-1:0]   feat_p0  [MUL_LAT];
    logic signed [WEIGHT_W-1:0] wt_p0    [MUL_LAT];
    logic signed [ACC_W-1:0]    shift_p0 [MUL_LAT];
    logic                       mode_p0  [MUL_LAT];

    logic signed [PROD_W-1:0]   prod_m;
    logic signed [ACC_W-1:0]    prod_ext;

    state_t                     state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]           tap_q, tap_d;
    logic                       sticky_q, sticky_d;

    logic                       res_vld_d;
    logic signed [ACC_W-1:0]    res_d;
    logic                       res_sat_d;

    logic signed [ACC_W-1:0]    base;
    logic signed [ACC_W:0]      chain_sum;
    logic signed [ACC_W:0]      local_sum;
    logic signed [ACC_W-1:0]    acc_new;
    logic                       sat_new;

    // A weight presented together with a sample applies to that sample directly.
    assign eff_wt = k_weight_valid ? kernel_weight : wt_q;

    // Kernel weight register: survives i_clear, only reset or a new load changes it.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            wt_q <= '0;
        end else if (k_weight_valid) begin
            wt_q <= kernel_weight;
        end
    end

    // Issue / multiply stage valid chain: clear drops every entry in flight,
    // including a sample offered in the clearing cycle.
    always_ff @(posedge s_clk) begin
        if (s_rst || i_clear) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                vld_p0[i] <= 1'b0;
            end
        end else begin
            vld_p0[0] <= f_data_valid;
            for (int i = 1; i < MUL_LAT; i++) begin
                vld_p0[i] <= vld_p0[i-1];
            end
        end
    end

    // Issue / multiply stage operands: captured on a valid sample, then carried
    // alongside the valid bit for the remaining multiplier latency.
    always_ff @(posedge s_clk) begin
        if (f_data_valid) begin
            feat_p0[0]  <= feature_data;
            wt_p0[0]    <= eff_wt;
            shift_p0[0] <= shift_data;
            mode_p0[0]  <= i_mode;
        end
        for (int i = 1; i < MUL_LAT; i++) begin
            feat_p0[i]  <= feat_p0[i-1];
            wt_p0[i]    <= wt_p0[i-1];
            shift_p0[i] <= shift_p0[i-1];
            mode_p0[i]  <= mode_p0[i-1];
        end
    end

    // Full-width signed product, sign-extended into the accumulator width.
    always_comb begin
        prod_m   = PROD_W'(feat_p0[LAST]) * PROD_W'(wt_p0[LAST]);
        prod_ext = ACC_W'(prod_m);
    end

    // Add stage: chain entries bypass the group state; local entries walk the FSM.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        tap_d     = tap_q;
        sticky_d  = sticky_q;
        res_vld_d = 1'b0;
        res_d     = o_mac_rlst_out;
        res_sat_d = o_sat;

        base      = (state_q == ST_IDLE) ? shift_p0[LAST] : acc_q;
        chain_sum = wide_add(prod_ext, shift_p0[LAST]);
        local_sum = wide_add(prod_ext, base);
        acc_new   = sat_clamp(local_sum);
        sat_new   = ((state_q == ST_IDLE) ? 1'b0 : sticky_q) | sat_ovf(local_sum);

        if (vld_p0[LAST]) begin
            if (!mode_p0[LAST]) begin
                res_vld_d = 1'b1;
                res_d     = sat_clamp(chain_sum);
                res_sat_d = sat_ovf(chain_sum);
            end else if (tap_q == CNT_W'(TAPS - 1)) begin
                res_vld_d = 1'b1;
                res_d     = acc_new;
                res_sat_d = sat_new;
                state_d   = ST_IDLE;
                tap_d     = '0;
                acc_d     = '0;
                sticky_d  = 1'b0;
            end else begin
                state_d   = ST_ACCUM;
                tap_d     = tap_q + CNT_W'(1);
                acc_d     = acc_new;
                sticky_d  = sat_new;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge s_clk) begin
        if (s_rst || i_clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Group accumulator, tap counter and sticky saturation flag.
    always_ff @(posedge s_clk) begin
        if (s_rst || i_clear) begin
            acc_q    <= '0;
            tap_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            tap_q    <= tap_d;
            sticky_q <= sticky_d;
        end
    end

    // Result register: strobe for one cycle, data and flag hold between strobes.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            o_mac_rlst_valid <= 1'b0;
            o_mac_rlst_out   <= '0;
            o_sat            <= 1'b0;
        end else if (i_clear) begin
            o_mac_rlst_valid <= 1'b0;
        end else begin
            o_mac_rlst_valid <= res_vld_d;
            o_mac_rlst_out   <= res_d;
            o_sat            <= res_sat_d;
        end
    end

endmodule

// File: tb/tb_pe_mac_acc_unit.sv
// Directed bench for pe_mac_acc_unit: default instance plus an ACC_W=16
// instance sharing the same stimulus for the saturation scenario.
module tb_pe_mac_acc_unit;

    logic               s_clk = 1'b0;
    logic               s_rst;
    logic               k_weight_valid;
    logic signed [7:0]  kernel_weight;
    logic               f_data_valid;
    logic signed [7:0]  feature_data;
    logic signed [19:0] shift_data;
    logic               i_mode;
    logic               i_clear;

    logic               o_vld;
    logic signed [19:0] o_out;
    logic               o_sat;
    logic               o_vld16;
    logic signed [15:0] o_out16;
    logic               o_sat16;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int t9;
    int t9b;

    int q_val[$];
    int q_sat[$];
    int q_cyc[$];
    int q16_val[$];
    int q16_sat[$];

    pe_mac_acc_unit dut (
        .s_clk            (s_clk),
        .s_rst            (s_rst),
        .k_weight_valid   (k_weight_valid),
        .kernel_weight    (kernel_weight),
        .f_data_valid     (f_data_valid),
        .feature_data     (feature_data),
        .shift_data       (shift_data),
        .i_mode           (i_mode),
        .i_clear          (i_clear),
        .o_mac_rlst_valid (o_vld),
        .o_mac_rlst_out   (o_out),
        .o_sat            (o_sat)
    );

    pe_mac_acc_unit #(.ACC_W(16)) dut16 (
        .s_clk            (s_clk),
        .s_rst            (s_rst),
        .k_weight_valid   (k_weight_valid),
        .kernel_weight    (kernel_weight),
        .f_data_valid     (f_data_valid),
        .feature_data     (feature_data),
        .shift_data       (shift_data[15:0]),
        .i_mode           (i_mode),
        .i_clear          (i_clear),
        .o_mac_rlst_valid (o_vld16),
        .o_mac_rlst_out   (o_out16),
        .o_sat            (o_sat16)
    );

    always #5 s_clk = ~s_clk;

    always @(posedge s_clk) cyc <= cyc + 1;

    always @(negedge s_clk) begin
        if (o_vld) begin
            q_val.push_back(int'(o_out));
            q_sat.push_back(int'(o_sat));
            q_cyc.push_back(cyc);
        end
        if (o_vld16) begin
            q16_val.push_back(int'(o_out16));
            q16_sat.push_back(int'(o_sat16));
        end
    end

    function automatic int qv(input int i);
        return (i < q_val.size()) ? q_val[i] : -99999999;
    endfunction
    function automatic int qs(input int i);
        return (i < q_sat.size()) ? q_sat[i] : -1;
    endfunction
    function automatic int qc(input int i);
        return (i < q_cyc.size()) ? q_cyc[i] : -99999999;
    endfunction
    function automatic int q16v(input int i);
        return (i < q16_val.size()) ? q16_val[i] : -99999999;
    endfunction
    function automatic int q16s(input int i);
        return (i < q16_sat.size()) ? q16_sat[i] : -1;
    endfunction

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic q_clear();
        q_val.delete();
        q_sat.delete();
        q_cyc.delete();
        q16_val.delete();
        q16_sat.delete();
    endtask

    task automatic send(input logic ld, input int w, input int d, input int sh, input logic md);
        k_weight_valid = ld;
        kernel_weight  = w[7:0];
        feature_data   = d[7:0];
        shift_data     = sh[19:0];
        i_mode         = md;
        f_data_valid   = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        f_data_valid   = 1'b0;
        k_weight_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        repeat (2) tick();
        checks++; if (o_vld !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_vld); end
        checks++; if (o_out !== 20'sd0) begin fails++; $display("FAIL reset_out got %0d want 0", o_out); end
        checks++; if (o_sat !== 1'b0) begin fails++; $display("FAIL reset_sat got %b want 0", o_sat); end
        checks++; if (o_vld16 !== 1'b0) begin fails++; $display("FAIL reset_valid16 got %b want 0", o_vld16); end
        s_rst = 1'b0;
        k_weight_valid = 1'b1;
        kernel_weight  = -8'sd3;
        tick();
        k_weight_valid = 1'b0;
        tick();
    endtask

    task automatic test_chain();
        q_clear();
        send(1'b0, 0, 5, 100, 1'b0);
        f_data_valid = 1'b0;
        checks++; if (o_vld !== 1'b0) begin fails++; $display("FAIL chain_early_valid got %b want 0", o_vld); end
        tick();
        checks++; if (o_vld !== 1'b1) begin fails++; $display("FAIL chain_latency_valid got %b want 1", o_vld); end
        checks++; if (int'(o_out) !== 85) begin fails++; $display("FAIL chain_out got %0d want 85", o_out); end
        checks++; if (o_sat !== 1'b0) begin fails++; $display("FAIL chain_sat got %b want 0", o_sat); end
        tick();
        checks++; if (o_vld !== 1'b0) begin fails++; $display("FAIL chain_one_cycle got %b want 0", o_vld); end

        q_clear();
        for (int i = 1; i <= 4; i++) send(1'b0, 0, i, 0, 1'b0);
        idle(4);
        checks++; if (q_val.size() !== 4) begin fails++; $display("FAIL chain_stream_count got %0d want 4", q_val.size()); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (qv(i-1) !== -3 * i) begin fails++; $display("FAIL chain_stream_val%0d got %0d want %0d", i, qv(i-1), -3 * i); end
        end
        checks++; if (qc(3) - qc(0) !== 3) begin fails++; $display("FAIL chain_stream_spacing got %0d want 3", qc(3) - qc(0)); end

        q_clear();
        send(1'b1, 1, 1, 524287, 1'b0);
        send(1'b1, -1, 1, -524288, 1'b0);
        idle(3);
        checks++; if (qv(0) !== 524287) begin fails++; $display("FAIL chain_sat_pos_val got %0d want 524287", qv(0)); end
        checks++; if (qs(0) !== 1) begin fails++; $display("FAIL chain_sat_pos_flag got %0d want 1", qs(0)); end
        checks++; if (qv(1) !== -524288) begin fails++; $display("FAIL chain_sat_neg_val got %0d want -524288", qv(1)); end
        checks++; if (qs(1) !== 1) begin fails++; $display("FAIL chain_sat_neg_flag got %0d want 1", qs(1)); end
        checks++; if (int'(o_out) !== -524288 || o_vld !== 1'b0) begin fails++; $display("FAIL chain_hold got %0d/%b want -524288/0", o_out, o_vld); end
    endtask

    task automatic test_local();
        q_clear();
        for (int i = 1; i <= 9; i++) begin
            if (i == 9) t9 = cyc;
            send(1'b1, i, 2, (i == 1) ? 10 : 999, 1'b1);
        end
        idle(4);
        checks++; if (q_val.size() !== 1) begin fails++; $display("FAIL local_count got %0d want 1", q_val.size()); end
        checks++; if (qv(0) !== 100) begin fails++; $display("FAIL local_val got %0d want 100", qv(0)); end
        checks++; if (qs(0) !== 0) begin fails++; $display("FAIL local_sat got %0d want 0", qs(0)); end
        checks++; if (qc(0) - t9 !== 2) begin fails++; $display("FAIL local_latency got %0d want 2", qc(0) - t9); end

        q_clear();
        for (int i = 1; i <= 9; i++) begin
            send(1'b1, i, 2, (i == 1) ? 10 : 999, 1'b1);
            if (i == 4) idle(3);
        end
        idle(4);
        checks++; if (q_val.size() !== 1) begin fails++; $display("FAIL local_gap_count got %0d want 1", q_val.size()); end
        checks++; if (qv(0) !== 100) begin fails++; $display("FAIL local_gap_val got %0d want 100", qv(0)); end
    endtask

    task automatic test_back_to_back();
        q_clear();
        for (int i = 1; i <= 9; i++) send(1'b1, i, 2, (i == 1) ? 10 : 0, 1'b1);
        send(1'b1, 1, 3, 5, 1'b1);
        for (int i = 2; i <= 9; i++) begin
            if (i == 9) t9b = cyc;
            send(1'b0, 0, 3, 0, 1'b1);
        end
        idle(4);
        checks++; if (q_val.size() !== 2) begin fails++; $display("FAIL b2b_count got %0d want 2", q_val.size()); end
        checks++; if (qv(0) !== 100) begin fails++; $display("FAIL b2b_first got %0d want 100", qv(0)); end
        checks++; if (qv(1) !== 32) begin fails++; $display("FAIL b2b_second got %0d want 32", qv(1)); end
        checks++; if (qc(1) - qc(0) !== 9) begin fails++; $display("FAIL b2b_spacing got %0d want 9", qc(1) - qc(0)); end
        checks++; if (qc(1) - t9b !== 2) begin fails++; $display("FAIL b2b_latency got %0d want 2", qc(1) - t9b); end
    endtask

    task automatic test_saturation();
        q_clear();
        for (int i = 1; i <= 9; i++) send(1'b1, -128, -128, 0, 1'b1);
        for (int i = 1; i <= 9; i++) send(i == 1, 1, 1, 0, 1'b1);
        idle(4);
        checks++; if (q16_val.size() !== 2) begin fails++; $display("FAIL sat16_count got %0d want 2", q16_val.size()); end
        checks++; if (q16v(0) !== 32767) begin fails++; $display("FAIL sat16_val got %0d want 32767", q16v(0)); end
        checks++; if (q16s(0) !== 1) begin fails++; $display("FAIL sat16_flag got %0d want 1", q16s(0)); end
        checks++; if (q16v(1) !== 9) begin fails++; $display("FAIL sat16_next_val got %0d want 9", q16v(1)); end
        checks++; if (q16s(1) !== 0) begin fails++; $display("FAIL sat16_next_flag got %0d want 0", q16s(1)); end
        checks++; if (qv(0) !== 147456) begin fails++; $display("FAIL sat20_val got %0d want 147456", qv(0)); end
        checks++; if (qs(0) !== 0) begin fails++; $display("FAIL sat20_flag got %0d want 0", qs(0)); end
    endtask

    task automatic test_clear();
        q_clear();
        send(1'b1, 5, 7, 1000, 1'b1);
        for (int i = 2; i <= 5; i++) send(1'b0, 0, 7, 0, 1'b1);
        i_clear = 1'b1;
        send(1'b0, 0, 100, 0, 1'b1);
        i_clear = 1'b0;
        send(1'b0, 0, 2, 0, 1'b0);
        send(1'b1, 1, 1, 2, 1'b1);
        for (int i = 2; i <= 9; i++) send(1'b0, 0, 1, 0, 1'b1);
        idle(4);
        checks++; if (q_val.size() !== 2) begin fails++; $display("FAIL clear_count got %0d want 2", q_val.size()); end
        checks++; if (qv(0) !== 10) begin fails++; $display("FAIL clear_weight_kept got %0d want 10", qv(0)); end
        checks++; if (qv(1) !== 11) begin fails++; $display("FAIL clear_group got %0d want 11", qv(1)); end
        checks++; if (qs(1) !== 0) begin fails++; $display("FAIL clear_group_sat got %0d want 0", qs(1)); end
    endtask

    task automatic test_chain_inject();
        q_clear();
        for (int i = 1; i <= 9; i++) begin
            send(1'b1, 2, 3, 0, 1'b1);
            if (i == 4) send(1'b1, 1, 1, 7, 1'b0);
        end
        idle(4);
        checks++; if (q_val.size() !== 2) begin fails++; $display("FAIL inject_count got %0d want 2", q_val.size()); end
        checks++; if (qv(0) !== 8) begin fails++; $display("FAIL inject_chain got %0d want 8", qv(0)); end
        checks++; if (qv(1) !== 54) begin fails++; $display("FAIL inject_local got %0d want 54", qv(1)); end
    endtask

    task automatic test_reset_inflight();
        q_clear();
        send(1'b1, 2, 3, 1, 1'b0);
        s_rst = 1'b1;
        send(1'b0, 0, 3, 1, 1'b0);
        s_rst = 1'b0;
        f_data_valid = 1'b0;
        checks++; if (o_vld !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", o_vld); end
        checks++; if (o_out !== 20'sd0) begin fails++; $display("FAIL rst_out got %0d want 0", o_out); end
        checks++; if (o_sat !== 1'b0) begin fails++; $display("FAIL rst_sat got %b want 0", o_sat); end
        idle(4);
        checks++; if (q_val.size() !== 0) begin fails++; $display("FAIL rst_no_strobe got %0d want 0", q_val.size()); end
        send(1'b0, 0, 9, 123, 1'b0);
        idle(3);
        checks++; if (qv(0) !== 123) begin fails++; $display("FAIL rst_weight_zero got %0d want 123", qv(0)); end
    endtask

    initial begin
        s_rst          = 1'b0;
        k_weight_valid = 1'b0;
        kernel_weight  = '0;
        f_data_valid   = 1'b0;
        feature_data   = '0;
        shift_data     = '0;
        i_mode         = 1'b0;
        i_clear        = 1'b0;
        tick();
        test_reset();
        test_chain();
        test_local();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_chain_inject();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
